gate_bist_ctrl: RTL and testbench

- Parametrised built-in self-test controller for the gate-library combinational models.
- Drives a model's inputs from an LFSR pattern generator and compresses its outputs into a MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Generalises the fixed 24-in/10-out gate models to any input/output width and to models with registered latency.

---
 rtl/gate_bist_ctrl.sv | 135 +++++++++++++
 tb/tb_gate_bist_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// LFSR-driven BIST controller: PAT_CNT patterns out on dut_in, MISR-compacted dut_out, pass vs exp_sig.
// Latency: done rises PAT_CNT+LAT cycles after start is taken; no backpressure, abort returns to IDLE next edge.
module gate_bist_ctrl #(
  parameter int               N_IN     = 24,
  parameter int               N_OUT    = 10,
  parameter int               PAT_CNT  = 1000,
  parameter int               LAT      = 0,
  parameter logic [N_IN-1:0]  IN_POLY  = 24'hE10000,
  parameter logic [N_OUT-1:0] OUT_POLY = 10'h240,
  parameter logic [N_IN-1:0]  SEED     = N_IN'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] exp_sig,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  dut_in,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
);

  localparam int              CW       = $clog2(PAT_CNT + 1);
  localparam logic [N_IN-1:0] SEED_EFF = (SEED == '0) ? N_IN'(1) : SEED;
  localparam logic [CW-1:0]   LAST     = CW'(PAT_CNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  lfsr;
  logic [N_OUT-1:0] misr;
  logic [CW-1:0]    cnt;
  logic             cap_valid;
  logic             flush_end;
  logic             load;

  assign pat_valid = (state == RUN);
  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign pass      = done && (misr == exp_sig);
  assign dut_in    = lfsr;
  assign signature = misr;

  // cap_valid marks the cycle in which dut_out reflects a counted pattern
  generate
    if (LAT == 0) begin : g_nolat
      assign cap_valid = pat_valid;
      assign flush_end = 1'b1;
    end else begin : g_lat
      localparam logic [LAT-1:0] VMSB = LAT'(1) << (LAT - 1);
      logic [LAT-1:0] vpipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe <= '0;
        end else if (abort) begin
          vpipe <= '0;
        end else begin
          vpipe <= LAT'({vpipe, pat_valid});
        end
      end

      assign cap_valid = vpipe[LAT-1];
      // only the oldest stage still set: this edge absorbs the last capture
      assign flush_end = (vpipe == VMSB);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_nxt = (LAT > 0) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        if (flush_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  // abort freezes lfsr/misr so the partial signature stays inspectable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_EFF;
      misr <= '0;
      cnt  <= '0;
    end else if (load) begin
      lfsr <= SEED_EFF;
      misr <= '0;
      cnt  <= '0;
    end else if (!abort) begin
      if (state == RUN) begin
        lfsr <= {lfsr[N_IN-2:0], ^(lfsr & IN_POLY)};
        cnt  <= cnt + CW'(1);
      end
      if (cap_valid) begin
        misr <= {misr[N_OUT-2:0], ^(misr & OUT_POLY)} ^ dut_out;
      end
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: four configurations, pattern/signature scoreboards.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // default configuration, dut_out driven by the bench
  logic        d_start, d_abort, d_pv, d_busy, d_done, d_pass;
  logic [9:0]  d_exp, d_out, d_sig;
  logic [23:0] d_in;
  gate_bist_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort), .exp_sig(d_exp),
    .dut_out(d_out), .dut_in(d_in), .pat_valid(d_pv), .busy(d_busy), .done(d_done),
    .pass(d_pass), .signature(d_sig));

  // 4-bit, 16 patterns, combinational loopback
  logic       a_start, a_abort, a_pv, a_busy, a_done, a_pass;
  logic [3:0] a_exp, a_in, a_sig;
  gate_bist_ctrl #(.N_IN(4), .N_OUT(4), .PAT_CNT(16), .LAT(0), .IN_POLY(4'hC),
                   .OUT_POLY(4'hC), .SEED(4'h1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .exp_sig(a_exp),
    .dut_out(a_in), .dut_in(a_in), .pat_valid(a_pv), .busy(a_busy), .done(a_done),
    .pass(a_pass), .signature(a_sig));

  // same, but loopback through two registers and LAT=2
  logic       l_start, l_abort, l_pv, l_busy, l_done, l_pass;
  logic [3:0] l_exp, l_in, l_sig, l_d1, l_d2;
  always @(posedge clk) begin
    l_d1 <= l_in;
    l_d2 <= l_d1;
  end
  gate_bist_ctrl #(.N_IN(4), .N_OUT(4), .PAT_CNT(16), .LAT(2), .IN_POLY(4'hC),
                   .OUT_POLY(4'hC), .SEED(4'h1)) u_l (
    .clk(clk), .rst_n(rst_n), .start(l_start), .abort(l_abort), .exp_sig(l_exp),
    .dut_out(l_d2), .dut_in(l_in), .pat_valid(l_pv), .busy(l_busy), .done(l_done),
    .pass(l_pass), .signature(l_sig));

  // 3 patterns, constant dut_out
  logic       m_start, m_abort, m_pv, m_busy, m_done, m_pass;
  logic [3:0] m_exp, m_out, m_in, m_sig;
  gate_bist_ctrl #(.N_IN(4), .N_OUT(4), .PAT_CNT(3), .LAT(0), .IN_POLY(4'hC),
                   .OUT_POLY(4'hC), .SEED(4'h1)) u_m (
    .clk(clk), .rst_n(rst_n), .start(m_start), .abort(m_abort), .exp_sig(m_exp),
    .dut_out(m_out), .dut_in(m_in), .pat_valid(m_pv), .busy(m_busy), .done(m_done),
    .pass(m_pass), .signature(m_sig));

  logic [3:0] pat_tab [16];
  logic [3:0] a_q[$], a_sq[$], l_sq[$];
  int         a_pv_n, a_last_pv, a_done_cyc;
  logic       a_done_q = 1'b0;
  logic       l_done_q = 1'b0;

  function automatic logic [3:0] misr_model(input int n);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m = {m[2:0], ^(m & 4'hC)} ^ pat_tab[i];
    return m;
  endfunction

  task automatic push_patterns();
    for (int i = 0; i < 16; i++) a_q.push_back(pat_tab[i]);
  endtask

  // scoreboard consumers
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_pv) begin
        a_pv_n++;
        a_last_pv = cyc;
        check("a_pat_pending", 64'(a_q.size() > 0), 1);
        if (a_q.size() > 0) check("a_pat", a_in, a_q.pop_front());
      end
      if (a_done && !a_done_q) begin
        a_done_cyc = cyc;
        check("a_sig_pending", 64'(a_sq.size() > 0), 1);
        if (a_sq.size() > 0) check("a_sig", a_sig, a_sq.pop_front());
      end
      if (l_done && !l_done_q) begin
        check("l_sig_pending", 64'(l_sq.size() > 0), 1);
        if (l_sq.size() > 0) check("l_sig", l_sig, l_sq.pop_front());
      end
    end
    a_done_q = a_done;
    l_done_q = l_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, busy_n;
    pat_tab = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    rst_n = 1'b0;
    {d_start, d_abort, a_start, a_abort, l_start, l_abort, m_start, m_abort} = '0;
    d_exp = '0; d_out = '0; a_exp = '0; l_exp = '0; m_exp = 4'h7; m_out = 4'h1;
    a_pv_n = 0; a_last_pv = 0; a_done_cyc = 0;

    #12;
    check("rst_a_in", a_in, 4'h1);   check("rst_a_pv", a_pv, 0);
    check("rst_a_busy", a_busy, 0);  check("rst_a_done", a_done, 0);
    check("rst_a_pass", a_pass, 0);  check("rst_a_sig", a_sig, 0);
    check("rst_d", {d_in, d_pv, d_busy, d_done, d_pass, d_sig}, {24'h1, 4'b0, 10'h0});
    check("rst_l", {l_in, l_pv, l_busy, l_done, l_pass, l_sig}, {4'h1, 4'b0, 4'h0});
    check("rst_m", {m_in, m_pv, m_busy, m_done, m_pass, m_sig}, {4'h1, 4'b0, 4'h0});
    @(negedge clk) rst_n = 1'b1;

    // single start pulse from IDLE
    push_patterns();
    a_sq.push_back(misr_model(16));
    a_exp = misr_model(16);
    a_pv_n = 0;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    for (int i = 0; i < 100 && !a_done; i++) @(negedge clk);
    @(negedge clk);
    check("a_done", a_done, 1);
    check("a_pass", a_pass, 1);
    check("a_pv_count", a_pv_n, 16);
    check("a_done_lat", a_done_cyc - a_last_pv, 1);
    check("a_q_drained", a_q.size(), 0);

    // start held through the whole run (restart from DONE), dropped once done is seen
    push_patterns();
    a_sq.push_back(misr_model(16));
    a_pv_n = 0;
    @(negedge clk) a_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_done) break;
    end
    a_start = 1'b0;
    @(negedge clk);
    check("held_pv_count", a_pv_n, 16);
    check("held_done", a_done, 1);
    check("held_no_restart", a_busy, 0);

    // restart with a single pulse while in DONE
    push_patterns();
    a_sq.push_back(misr_model(16));
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    check("restart_done_drop", a_done, 0);
    for (int i = 0; i < 100 && !a_done; i++) @(negedge clk);
    @(negedge clk);
    check("restart_sig", a_sig, misr_model(16));

    // default configuration, zero outputs
    @(negedge clk) d_start = 1'b1;
    @(negedge clk) d_start = 1'b0;
    for (int i = 0; i < 1100 && !d_done; i++) @(negedge clk);
    check("def_done", d_done, 1);
    check("def_sig", d_sig, 10'h0);
    check("def_pass", d_pass, 1);
    d_exp = 10'h001;
    #1 check("def_fail", d_pass, 0);

    // constant-input compaction
    @(negedge clk) m_start = 1'b1;
    @(negedge clk) m_start = 1'b0;
    for (int i = 0; i < 20 && !m_done; i++) @(negedge clk);
    check("m_sig", m_sig, 4'h7);
    check("m_pass", m_pass, 1);

    // latency-2 loopback
    l_sq.push_back(misr_model(16));
    l_exp = misr_model(16);
    busy_n = 0;
    @(negedge clk) l_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      l_start = 1'b0;
      if (l_busy) busy_n++;
      if (l_done) break;
    end
    check("l_busy_cycles", busy_n, 18);
    check("l_pass", l_pass, 1);

    // abort at cnt=5
    push_patterns();
    seen = 0;
    @(negedge clk) a_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (a_pv) seen++;
      if (seen == 6) break;
    end
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    a_q.delete();
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_pass", a_pass, 0);
    check("abort_sig", a_sig, misr_model(5));
    check("abort_lfsr", a_in, 4'h6);
    repeat (3) @(negedge clk);
    check("abort_frozen", a_sig, misr_model(5));

    // start and abort together: abort wins
    a_start = 1'b1; a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_abort = 1'b0;
    check("start_abort_idle", {a_busy, a_done}, 2'b00);

    // asynchronous reset mid-run
    push_patterns();
    @(negedge clk) a_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_in", a_in, 4'h1);
    check("arst_flags", {a_pv, a_busy, a_done, a_pass}, 4'b0000);
    check("arst_sig", a_sig, 4'h0);
    a_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("arst_stays_idle", a_busy, 0);
    check("sig_q_drained", a_sq.size() + l_sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
